// File: rtl/expr_eval.sv
// -----------------------------------------------------------------------------
// expr_eval
//
// Streaming arithmetic evaluator for ASCII expressions of the form
//   digit (op digit)*     where op is '+' or '*' and every digit is 0..9.
// '*' binds tighter than '+'. The running value of the expression is kept as
// a completed additive part (sum) plus the multiplicative term that is still
// being built (term), so each character is absorbed in a single cycle.
// Any character that breaks the grammar drops the block into a sticky error
// state that only the asynchronous reset can leave.
//
// Parameters:
//   WIDTH     accumulator / result width; all arithmetic wraps modulo 2^WIDTH
//
// Ports:
//   clk       system clock, rising edge active
//   clr       asynchronous active-low reset
//   in        ASCII character presented to the block
//   in_valid  1: consume `in` on this edge; 0: every register holds
//   result    registered value of the expression evaluated so far
//   out       registered: 1 when the consumed characters form a complete,
//             legal expression (last one a digit, no error)
//   err       registered sticky syntax-error flag
// -----------------------------------------------------------------------------
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             out,
  output logic             err
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_NUM   = 3'd1,
    S_ADD   = 3'd2,
    S_MUL   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic [WIDTH-1:0] term_q,   term_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_q,    out_d;
  logic             err_q,    err_d;

  logic             is_digit_s;
  logic             is_add_s;
  logic             is_mul_s;
  logic [WIDTH-1:0] digit_ext_s;
  logic [WIDTH-1:0] product_s;
  logic [WIDTH-1:0] sum_plus_digit_s;
  logic [WIDTH-1:0] sum_plus_product_s;

  // Character classification and the arithmetic candidates for this cycle.
  always_comb begin
    is_digit_s = (in >= 8'h30) && (in <= 8'h39);
    is_add_s   = (in == 8'h2B);
    is_mul_s   = (in == 8'h2A);
    // For '0'..'9' (0x30..0x39) the low nibble is already the digit value;
    // the value is only used when is_digit_s is set.
    digit_ext_s = {{(WIDTH-4){1'b0}}, in[3:0]};
    // WIDTH x WIDTH product kept at WIDTH bits is exactly the truncated
    // WIDTH x 4 product, since the upper operand bits are zero.
    product_s          = term_q * digit_ext_s;
    sum_plus_digit_s   = sum_q + digit_ext_s;
    sum_plus_product_s = sum_q + product_s;
  end

  // Next-state and next-output computation for one consumed character.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    term_d   = term_q;
    result_d = result_q;
    out_d    = out_q;
    err_d    = err_q;

    if (in_valid) begin
      case (state_q)
        S_START: begin
          if (is_digit_s) begin
            state_d  = S_NUM;
            term_d   = digit_ext_s;
            result_d = digit_ext_s;
            out_d    = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            out_d   = 1'b0;
          end
        end

        S_NUM: begin
          if (is_add_s) begin
            // Close the current term into the additive part.
            state_d = S_ADD;
            sum_d   = sum_q + term_q;
            out_d   = 1'b0;
          end else if (is_mul_s) begin
            state_d = S_MUL;
            out_d   = 1'b0;
          end else begin
            // A second digit (multi-digit number) is as illegal as junk.
            state_d = S_ERR;
            err_d   = 1'b1;
            out_d   = 1'b0;
          end
        end

        S_ADD: begin
          if (is_digit_s) begin
            state_d  = S_NUM;
            term_d   = digit_ext_s;
            result_d = sum_plus_digit_s;
            out_d    = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            out_d   = 1'b0;
          end
        end

        S_MUL: begin
          if (is_digit_s) begin
            state_d  = S_NUM;
            term_d   = product_s;
            result_d = sum_plus_product_s;
            out_d    = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            out_d   = 1'b0;
          end
        end

        S_ERR: begin
          // Terminal: absorb everything, outputs frozen.
          state_d = S_ERR;
          err_d   = 1'b1;
          out_d   = 1'b0;
        end

        default: begin
          // Unreachable encodings are treated as a syntax failure.
          state_d = S_ERR;
          err_d   = 1'b1;
          out_d   = 1'b0;
        end
      endcase
    end else begin
      state_d  = state_q;
      sum_d    = sum_q;
      term_d   = term_q;
      result_d = result_q;
      out_d    = out_q;
      err_d    = err_q;
    end
  end

  // State, accumulators and registered outputs; reset is asynchronous.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_START;
      sum_q    <= {WIDTH{1'b0}};
      term_q   <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      out_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      term_q   <= term_d;
      result_q <= result_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign out    = out_q;
  assign err    = err_q;

endmodule
